// File: rtl/branch_tracker_pkg.sv
// Shared types for the branch tracker: branch unit result packet, tracker
// state enum and the branch-mask width.
package branch_tracker_pkg;

  localparam int BM_WIDTH = 4;

  typedef struct packed {
    logic                valid;
    logic [BM_WIDTH-1:0] bmm;
    logic                bm_mispred;
    logic [31:0]         target_PC;
    logic                actual_taken;
    logic                predict_taken;
  } BRANCH_REG_PACKET;

  typedef enum logic {
    BT_NORMAL  = 1'b0,
    BT_RECOVER = 1'b1
  } BR_TRACK_STATE;

endpackage

// File: rtl/branch_tracker_lowest_free_sel.sv
// One-hot selector of the lowest set bit of an N-bit vector; used to pick the
// free branch-mask entry with the smallest index.
module lowest_free_sel #(
  parameter int N = 4
) (
  input  logic [N-1:0] vec_i,
  output logic [N-1:0] onehot_o,
  output logic         any_o
);

  // Two's-complement trick isolates the lowest set bit.
  assign onehot_o = vec_i & (~vec_i + N'(1));
  assign any_o    = |vec_i;

endmodule

// File: rtl/branch_tracker.sv
// Tracks outstanding branches: hands out one-hot mask bits at dispatch and
// turns branch-unit results into registered clear/squash broadcasts.
module branch_tracker
  import branch_tracker_pkg::*;
#(
  parameter int N_BR = BM_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             alloc_req,
  output logic             alloc_gnt,
  output logic [N_BR-1:0]  alloc_mask,
  output logic [N_BR-1:0]  cur_mask,
  input  BRANCH_REG_PACKET branch_reg_result,
  output logic             resolve_valid,
  output logic [N_BR-1:0]  resolve_mask,
  output logic             squash,
  output logic [N_BR-1:0]  squash_mask,
  output logic [31:0]      redirect_PC,
  input  logic [31:0]      alloc_npc,
  output logic             bad_resolve,
  output logic             dbg_state
);

  // Handshake: alloc_req is a per-cycle request; alloc_gnt/alloc_mask answer it
  // combinationally in the same cycle and the entry is taken on the next edge.
  // Resolve results are accepted whenever branch_reg_result.valid is high.

  BR_TRACK_STATE   state_q;
  logic [N_BR-1:0] busy_q, busy_d;
  logic [N_BR-1:0] dep_q [N_BR];
  logic [N_BR-1:0] dep_d [N_BR];
  logic [31:0]     npc_q [N_BR];

  logic            resolve_valid_q, squash_q, bad_resolve_q;
  logic [N_BR-1:0] resolve_mask_q, squash_mask_q;
  logic [31:0]     redirect_pc_q;

  logic [N_BR-1:0] bmm;
  logic            res_valid, res_mispred, bmm_onehot, res_hit;
  logic            correct_ok, mispred_ok;
  logic [N_BR-1:0] younger, clear_vec, squash_vec;
  logic [N_BR-1:0] free_onehot;
  logic            any_free;
  logic [31:0]     npc_sel, redirect_d;
  logic            unused_pred;

  assign bmm         = branch_reg_result.bmm;
  assign res_valid   = branch_reg_result.valid;
  assign res_mispred = branch_reg_result.bm_mispred;
  assign unused_pred = branch_reg_result.predict_taken;

  assign bmm_onehot = (bmm != '0) && ((bmm & (bmm - N_BR'(1))) == '0);
  assign res_hit    = res_valid && bmm_onehot && ((bmm & busy_q) != '0);
  assign correct_ok = res_hit && !res_mispred;
  assign mispred_ok = res_hit && res_mispred;

  lowest_free_sel #(.N(N_BR)) u_free_sel (
    .vec_i   (~busy_q),
    .onehot_o(free_onehot),
    .any_o   (any_free)
  );

  assign alloc_gnt  = reset_n && alloc_req && any_free && (state_q == BT_NORMAL) &&
                      !(res_valid && res_mispred);
  assign alloc_mask = alloc_gnt ? free_onehot : '0;

  always_comb begin
    younger = '0;
    npc_sel = '0;
    for (int j = 0; j < N_BR; j++) begin
      younger[j] = busy_q[j] && ((dep_q[j] & bmm) != '0);
      if (bmm[j]) npc_sel = npc_sel | npc_q[j];
    end
    redirect_d = branch_reg_result.actual_taken ? branch_reg_result.target_PC : npc_sel;
  end

  always_comb begin
    clear_vec  = correct_ok ? bmm : '0;
    squash_vec = mispred_ok ? (bmm | younger) : '0;
    busy_d     = (busy_q & ~clear_vec & ~squash_vec) | alloc_mask;
    for (int i = 0; i < N_BR; i++) begin
      dep_d[i] = dep_q[i] & ~clear_vec;
      // A branch resolving correctly this cycle is no longer older than the new one.
      if (alloc_mask[i]) dep_d[i] = busy_q & ~clear_vec;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= BT_NORMAL;
      busy_q          <= '0;
      for (int i = 0; i < N_BR; i++) begin
        dep_q[i] <= '0;
        npc_q[i] <= '0;
      end
      resolve_valid_q <= 1'b0;
      resolve_mask_q  <= '0;
      squash_q        <= 1'b0;
      squash_mask_q   <= '0;
      redirect_pc_q   <= '0;
      bad_resolve_q   <= 1'b0;
    end else begin
      busy_q <= busy_d;
      for (int i = 0; i < N_BR; i++) begin
        dep_q[i] <= dep_d[i];
        if (alloc_mask[i]) npc_q[i] <= alloc_npc;
      end
      case (state_q)
        BT_NORMAL:  if (mispred_ok) state_q <= BT_RECOVER;
        BT_RECOVER: state_q <= BT_NORMAL;
        default:    state_q <= BT_NORMAL;
      endcase
      resolve_valid_q <= res_hit;
      resolve_mask_q  <= res_hit ? bmm : '0;
      squash_q        <= mispred_ok;
      squash_mask_q   <= squash_vec;
      redirect_pc_q   <= mispred_ok ? redirect_d : '0;
      if (res_valid && !res_hit) bad_resolve_q <= 1'b1;
    end
  end

  assign cur_mask      = busy_q;
  assign resolve_valid = resolve_valid_q;
  assign resolve_mask  = resolve_mask_q;
  assign squash        = squash_q;
  assign squash_mask   = squash_mask_q;
  assign redirect_PC   = redirect_pc_q;
  assign bad_resolve   = bad_resolve_q;
  assign dbg_state     = (state_q == BT_RECOVER);

endmodule

// File: doc/branch_tracker.md
# branch_tracker

Tracks in-flight branches for the out-of-order core and closes the loop on the branch unit. At dispatch it assigns each branch a one-hot mask bit and gives every dispatched instruction the current outstanding-branch mask. At resolve it consumes the branch unit's `BRANCH_REG_PACKET` and broadcasts a registered clear or squash to the RS, ROB, and functional units, plus a fetch redirect on mispredict.

## Interface
- `N_BR`, default `` `BM_WIDTH `` (4): number of simultaneously outstanding branches; equals the width of the `bmm` field.
- `clock` in 1: core clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `alloc_req` in 1: dispatch has a branch/jump this cycle.
- `alloc_gnt` out 1: allocation accepted (combinational).
- `alloc_mask` out N_BR: one-hot bit given to the branch; zero when `alloc_gnt` is low.
- `cur_mask` out N_BR: registered set of outstanding branches, used to tag dispatched instructions.
- `branch_reg_result` in BRANCH_REG_PACKET: branch unit result (`valid`, `bmm`, `bm_mispred`, `target_PC`, `actual_taken`, `predict_taken`).
- `resolve_valid` out 1: registered resolve broadcast is valid.
- `resolve_mask` out N_BR: one-hot bit of the resolved branch.
- `squash` out 1: the resolved branch mispredicted.
- `squash_mask` out N_BR: resolved bit OR all younger outstanding bits; zero unless `squash` is high.
- `redirect_PC` out 32: `target_PC` if `actual_taken`, else stored NPC.
- `alloc_npc` in 32: NPC of the allocating branch, stored per entry.
- `bad_resolve` out 1: sticky flag set when a valid resolve names a bit that is not outstanding.

## Operation
- State per entry i: `busy[i]`, `dep[i]` (N_BR, the outstanding masks older than i), `npc[i]`.
- Allocation:
  - `alloc_gnt = alloc_req & |~busy & (state==NORMAL) & ~(valid & bm_mispred)`.
  - Grant goes to the lowest-index free entry.
  - On the edge: set `busy[i]`; set `dep[i] = busy & ~clear_this_cycle`; store `npc[i]`.
- Correct resolve (`valid & ~bm_mispred`, bit b busy):
  - Clear `busy[b]`.
  - Clear bit b from every `dep[j]`.
  - Register `resolve_valid=1`, `resolve_mask=b`, `squash=0`.
- Mispredict (`valid & bm_mispred`, bit b busy):
  - `younger = {j : busy[j] & dep[j][b]}`.
  - Clear `busy` for b and all younger entries.
  - Register `squash=1`, `squash_mask = b | younger`, and `redirect_PC`.
  - FSM moves to RECOVER.
- Resolve with `bmm` not one-hot or not busy: no state change, `bad_resolve` is set, no broadcast.
- FSM:
  - NORMAL → RECOVER on an accepted mispredict.
  - RECOVER → NORMAL unconditionally after one cycle.
  - Allocation is blocked in RECOVER.
- Width rules: all masks are N_BR bits. `dep[i][i]` is always 0.

## Timing
- Reset (async, `reset_n=0`): `busy=0`, `dep=0`, state NORMAL. Outputs `cur_mask=0`, `resolve_valid=0`, `resolve_mask=0`, `squash=0`, `squash_mask=0`, `redirect_PC=0`, `bad_resolve=0`. `alloc_gnt` is forced 0 while reset is asserted.
- Reset mid-operation discards all entries immediately; there is no pending broadcast.
- `alloc_gnt` and `alloc_mask` are same-cycle combinational. The allocated bit appears in `cur_mask` on the next cycle.
- Resolve outputs have 1-cycle latency from `branch_reg_result.valid`. They are held for exactly one cycle.
- Free list reads registered `busy`: a bit freed at edge k can be granted from cycle k onward, never in the same cycle as its free.
- Same-cycle allocation and correct resolve of b: the new entry's `dep` excludes b.
- Same-cycle allocation and mispredict: allocation is denied.
- Full (`&busy`): `alloc_gnt=0`. A resolve in that cycle frees the bit for the next cycle.
- Only one resolve per cycle is accepted. The branch unit is single-issue.

## Structure
- `N_BR`/`` `BM_WIDTH `` and `BRANCH_REG_PACKET` come from `sys_defs.svh`.
- Add `BR_TRACK_STATE` enum {BT_NORMAL, BT_RECOVER} to the shared package.
- Sub-module `lowest_free_sel`: parameterised N-bit lowest-set-bit one-hot selector, used for allocation.

## Test plan
- Reset, then 4 allocations on consecutive cycles → masks 0001, 0010, 0100, 1000. `cur_mask`=1111 and `alloc_gnt`=0 on the 5th request.
- Allocate b0,b1,b2; correct resolve of b1 → next cycle `resolve_valid`=1, `resolve_mask`=0010, `squash`=0, `cur_mask`=0101. `dep[2]` becomes 0001.
- Allocate b0..b3; mispredict b1 with `actual_taken`=1, `target_PC`=0x200 → `squash_mask`=1110, `redirect_PC`=0x200, `cur_mask`=0001. `alloc_gnt`=0 for the single RECOVER cycle.
- Mispredict not-taken on b0 with stored NPC 0x104 → `redirect_PC`=0x104. An `alloc_req` in the mispredict cycle is denied.
- Full tracker; correct resolve of b2 in the cycle a request is pending → request denied. The next cycle grants 0100.
- Resolve with `bmm`=0010 while not busy → `bad_resolve`=1 and no broadcast. Assert `reset_n` low mid-stream → all outputs return to 0 asynchronously.
